// File: rtl/instr_encoder_loader_if.sv
// Request bus for the instruction encoder/loader.
// The master drives a symbolic instruction request and the slave
// (the encoder) answers with req_ready.
interface instr_encoder_loader_if;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_mnem;
   logic [4:0]  req_rs;
   logic [4:0]  req_rt;
   logic [4:0]  req_rd;
   logic [4:0]  req_shamt;
   logic [25:0] req_imm;

   // Request source side
   modport master (
      output req_valid,
      output req_mnem,
      output req_rs,
      output req_rt,
      output req_rd,
      output req_shamt,
      output req_imm,
      input  req_ready
   );

   // Encoder side
   modport slave (
      input  req_valid,
      input  req_mnem,
      input  req_rs,
      input  req_rt,
      input  req_rd,
      input  req_shamt,
      input  req_imm,
      output req_ready
   );
endinterface

// File: rtl/instr_encoder_loader.sv
// Instruction encoder / program loader.
// Accepts symbolic instruction requests (mnemonic ID plus fields), packs
// each into a 32-bit MIPS word and writes the words sequentially into
// instruction memory starting at BASE_ADDR. A finish request ends loading.
//
// Optional feature macro: ENC_HALT_PAD_EN
//    When defined, finish (while not full) first writes a self-loop `j`
//    at the next free address before reaching DONE.
module instr_encoder_loader #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0,
   parameter int DEPTH     = 256
) (
   input  logic                     clk,
   input  logic                     reset,
   instr_encoder_loader_if.slave    req,
   input  logic                     finish,
   output logic                     im_we,
   output logic [ADDR_W-1:0]        im_addr,
   output logic [31:0]              im_wdata,
   output logic [ADDR_W:0]          count,
   output logic                     full,
   output logic                     done,
   output logic                     err
);

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

`ifdef ENC_HALT_PAD_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      HALT  = 2'd2,
      DONE  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd3
   } state_t;
`endif

   state_t            state;
   state_t            stateNext;

   logic              readyInt;
   logic              encLegal;
   logic [31:0]       encWord;
   logic              loadWord;
   logic [31:0]       wordNext;
   logic              errNext;
   logic              writeDone;
   logic [ADDR_W:0]   countInc;

   // R-type word: OpCode 0 with register, shamt and Funct fields
   function automatic logic [31:0] rType(
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic [4:0] rd,
      input logic [4:0] shamt,
      input logic [5:0] funct
   );
      return {6'd0, rs, rt, rd, shamt, funct};
   endfunction

   // I-type word: OpCode, rs, rt and a 16-bit immediate
   function automatic logic [31:0] iType(
      input logic [5:0]  op,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [15:0] imm
   );
      return {op, rs, rt, imm};
   endfunction

   // J-type word: OpCode and 26-bit target
   function automatic logic [31:0] jType(
      input logic [5:0]  op,
      input logic [25:0] target
   );
      return {op, target};
   endfunction

   // Encode the presented request; unused fields are forced to zero
   always_comb begin
      encLegal = 1'b1;
      encWord  = '0;
      case (req.req_mnem)
         5'd0:  encWord = rType(req.req_rs, req.req_rt, req.req_rd, 5'd0, 6'h20);
         5'd1:  encWord = rType(req.req_rs, req.req_rt, req.req_rd, 5'd0, 6'h21);
         5'd2:  encWord = rType(req.req_rs, req.req_rt, req.req_rd, 5'd0, 6'h22);
         5'd3:  encWord = rType(req.req_rs, req.req_rt, req.req_rd, 5'd0, 6'h23);
         5'd4:  encWord = rType(req.req_rs, req.req_rt, req.req_rd, 5'd0, 6'h24);
         5'd5:  encWord = rType(req.req_rs, req.req_rt, req.req_rd, 5'd0, 6'h25);
         5'd6:  encWord = rType(req.req_rs, req.req_rt, req.req_rd, 5'd0, 6'h26);
         5'd7:  encWord = rType(req.req_rs, req.req_rt, req.req_rd, 5'd0, 6'h27);
         5'd8:  encWord = rType(req.req_rs, req.req_rt, req.req_rd, 5'd0, 6'h2A);
         5'd9:  encWord = rType(req.req_rs, req.req_rt, req.req_rd, 5'd0, 6'h2B);
         5'd10: encWord = rType(5'd0, req.req_rt, req.req_rd, req.req_shamt, 6'h00);
         5'd11: encWord = rType(5'd0, req.req_rt, req.req_rd, req.req_shamt, 6'h02);
         5'd12: encWord = rType(5'd0, req.req_rt, req.req_rd, req.req_shamt, 6'h03);
         5'd13: encWord = rType(req.req_rs, 5'd0, 5'd0, 5'd0, 6'h08);
         5'd14: encWord = rType(req.req_rs, 5'd0, req.req_rd, 5'd0, 6'h09);
         5'd15: encWord = iType(6'd35, req.req_rs, req.req_rt, req.req_imm[15:0]);
         5'd16: encWord = iType(6'd43, req.req_rs, req.req_rt, req.req_imm[15:0]);
         5'd17: encWord = iType(6'd15, 5'd0, req.req_rt, req.req_imm[15:0]);
         5'd18: encWord = iType(6'd8, req.req_rs, req.req_rt, req.req_imm[15:0]);
         5'd19: encWord = iType(6'd9, req.req_rs, req.req_rt, req.req_imm[15:0]);
         5'd20: encWord = iType(6'd12, req.req_rs, req.req_rt, req.req_imm[15:0]);
         5'd21: encWord = iType(6'd10, req.req_rs, req.req_rt, req.req_imm[15:0]);
         5'd22: encWord = iType(6'd11, req.req_rs, req.req_rt, req.req_imm[15:0]);
         5'd23: encWord = iType(6'd4, req.req_rs, req.req_rt, req.req_imm[15:0]);
         5'd24: encWord = jType(6'd2, req.req_imm);
         5'd25: encWord = jType(6'd3, req.req_imm);
         default: begin
            encLegal = 1'b0;
            encWord  = '0;
         end
      endcase
   end

   // Status decode: ready only in IDLE with room left and reset released
   assign full          = (count == DEPTH_C);
   assign readyInt      = (state == IDLE) && !full && !reset;
   assign req.req_ready = readyInt;
   assign done          = (state == DONE);
   assign countInc      = count + CNT_ONE;

   // A memory write happens in every cycle spent in a writing state
`ifdef ENC_HALT_PAD_EN
   assign writeDone = (state == WRITE) || (state == HALT);
`else
   assign writeDone = (state == WRITE);
`endif
   assign im_we = writeDone;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic; an accepted request always takes priority over finish
   always_comb begin
      stateNext = state;
      loadWord  = 1'b0;
      wordNext  = encWord;
      errNext   = 1'b0;
      case (state)
         IDLE: begin
            if (req.req_valid && readyInt) begin
               if (encLegal) begin
                  stateNext = WRITE;
                  loadWord  = 1'b1;
               end else begin
                  errNext = 1'b1;
               end
            end else if (finish) begin
`ifdef ENC_HALT_PAD_EN
               if (full) begin
                  stateNext = DONE;
               end else begin
                  stateNext = HALT;
                  loadWord  = 1'b1;
                  wordNext  = {6'd2, 26'(im_addr)};
               end
`else
               stateNext = DONE;
`endif
            end
         end
         WRITE: begin
            stateNext = IDLE;
         end
`ifdef ENC_HALT_PAD_EN
         HALT: begin
            stateNext = DONE;
         end
`endif
         DONE: begin
            stateNext = DONE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Datapath: word register, error pulse, count and saturating address
   always_ff @(posedge clk) begin
      if (reset) begin
         im_addr  <= BASE_C;
         im_wdata <= '0;
         count    <= '0;
         err      <= 1'b0;
      end else begin
         err <= errNext;
         if (loadWord) begin
            im_wdata <= wordNext;
         end
         if (writeDone) begin
            count <= countInc;
            if (countInc < DEPTH_C) begin
               im_addr <= im_addr + ADR_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed testbench for instr_encoder_loader (DEPTH=4, BASE_ADDR=0).
// Handles builds with and without ENC_HALT_PAD_EN.
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        finish;
   logic        im_we;
   logic [7:0]  im_addr;
   logic [31:0] im_wdata;
   logic [8:0]  count;
   logic        full;
   logic        done;
   logic        err;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [4:0]  mnem;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [25:0] imm;
      logic [31:0] word;
   } vec_t;

   instr_encoder_loader_if reqBus();

   instr_encoder_loader #(
      .ADDR_W    (8),
      .BASE_ADDR (0),
      .DEPTH     (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (reqBus),
      .finish   (finish),
      .im_we    (im_we),
      .im_addr  (im_addr),
      .im_wdata (im_wdata),
      .count    (count),
      .full     (full),
      .done     (done),
      .err      (err)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [4:0] mnem, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd,
                                input logic [4:0] shamt, input logic [25:0] imm,
                                input logic valid);
      reqBus.req_mnem  = mnem;
      reqBus.req_rs    = rs;
      reqBus.req_rt    = rt;
      reqBus.req_rd    = rd;
      reqBus.req_shamt = shamt;
      reqBus.req_imm   = imm;
      reqBus.req_valid = valid;
   endtask

   task automatic resetDut();
      reset  = 1'b1;
      finish = 1'b0;
      applyStimulus(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      resetDut();
      reset = 1'b1;
      tick();
      vectors++; if (reqBus.req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ready: got %0b want 0", reqBus.req_ready); end
      vectors++; if (im_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_we: got %0b want 0", im_we); end
      vectors++; if (im_addr !== 8'd0) begin miscompares++; $display("[TB] FAIL rst_addr: got %0d want 0", im_addr); end
      vectors++; if (im_wdata !== 32'd0) begin miscompares++; $display("[TB] FAIL rst_wdata: got %h want 0", im_wdata); end
      vectors++; if (count !== 9'd0) begin miscompares++; $display("[TB] FAIL rst_count: got %0d want 0", count); end
      vectors++; if (full !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_flags: full=%0b done=%0b err=%0b want 000", full, done, err); end
      reset = 1'b0;
      #1;
      vectors++; if (reqBus.req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_release_ready: got %0b want 1", reqBus.req_ready); end
   endtask

   task automatic test_encode_full();
      vec_t v[4];
      v[0] = '{5'd0,  5'd1,  5'd2, 5'd3,  5'd0, 26'd0,      32'h00221820};
      v[1] = '{5'd15, 5'd29, 5'd8, 5'd31, 5'd0, 26'h0004,   32'h8FA80004};
      v[2] = '{5'd17, 5'd7,  5'd1, 5'd0,  5'd0, 26'h1001,   32'h3C011001};
      v[3] = '{5'd10, 5'd9,  5'd3, 5'd2,  5'd4, 26'd0,      32'h00031100};
      resetDut();
      applyStimulus(v[0].mnem, v[0].rs, v[0].rt, v[0].rd, v[0].shamt, v[0].imm, 1'b1);
      for (int i = 0; i < 4; i++) begin
         vectors++; if (reqBus.req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL enc%0d_ready: got %0b want 1", i, reqBus.req_ready); end
         tick();
         if (i < 3) applyStimulus(v[i+1].mnem, v[i+1].rs, v[i+1].rt, v[i+1].rd, v[i+1].shamt, v[i+1].imm, 1'b1);
         else       applyStimulus(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b1);
         vectors++; if (im_we !== 1'b1) begin miscompares++; $display("[TB] FAIL enc%0d_we: got %0b want 1", i, im_we); end
         vectors++; if (im_addr !== 8'(i)) begin miscompares++; $display("[TB] FAIL enc%0d_addr: got %0d want %0d", i, im_addr, i); end
         vectors++; if (im_wdata !== v[i].word) begin miscompares++; $display("[TB] FAIL enc%0d_wdata: got %h want %h", i, im_wdata, v[i].word); end
         vectors++; if (reqBus.req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL enc%0d_busy_ready: got %0b want 0", i, reqBus.req_ready); end
         tick();
         vectors++; if (im_we !== 1'b0) begin miscompares++; $display("[TB] FAIL enc%0d_we_low: got %0b want 0", i, im_we); end
         vectors++; if (count !== 9'(i+1)) begin miscompares++; $display("[TB] FAIL enc%0d_count: got %0d want %0d", i, count, i+1); end
      end
      vectors++; if (full !== 1'b1) begin miscompares++; $display("[TB] FAIL full_flag: got %0b want 1", full); end
      vectors++; if (reqBus.req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_ready: got %0b want 0", reqBus.req_ready); end
      for (int k = 0; k < 3; k++) begin
         tick();
         vectors++; if (im_we !== 1'b0) begin miscompares++; $display("[TB] FAIL full_stall%0d_we: got %0b want 0", k, im_we); end
      end
      vectors++; if (count !== 9'd4) begin miscompares++; $display("[TB] FAIL full_count: got %0d want 4", count); end
      vectors++; if (im_addr !== 8'd3) begin miscompares++; $display("[TB] FAIL full_addr: got %0d want 3", im_addr); end
      finish = 1'b1;
      tick();
      vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL full_done: got %0b want 1", done); end
      vectors++; if (im_we !== 1'b0) begin miscompares++; $display("[TB] FAIL full_done_we: got %0b want 0", im_we); end
      vectors++; if (count !== 9'd4) begin miscompares++; $display("[TB] FAIL full_done_count: got %0d want 4", count); end
      finish = 1'b0;
      applyStimulus(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
   endtask

   task automatic test_illegal_jump();
      resetDut();
      applyStimulus(5'd31, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b1);
      tick();
      applyStimulus(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
      vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL ill_err: got %0b want 1", err); end
      vectors++; if (im_we !== 1'b0) begin miscompares++; $display("[TB] FAIL ill_we: got %0b want 0", im_we); end
      tick();
      vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL ill_err_clear: got %0b want 0", err); end
      vectors++; if (count !== 9'd0) begin miscompares++; $display("[TB] FAIL ill_count: got %0d want 0", count); end
      applyStimulus(5'd25, 5'd0, 5'd0, 5'd0, 5'd0, 26'h0100010, 1'b1);
      tick();
      applyStimulus(5'd13, 5'd31, 5'd5, 5'd6, 5'd7, 26'd0, 1'b0);
      vectors++; if (im_we !== 1'b1 || im_addr !== 8'd0) begin miscompares++; $display("[TB] FAIL jal_write: got we=%0b addr=%0d want we=1 addr=0", im_we, im_addr); end
      vectors++; if (im_wdata !== 32'h0C100010) begin miscompares++; $display("[TB] FAIL jal_wdata: got %h want 0c100010", im_wdata); end
      tick();
      reqBus.req_valid = 1'b1;
      tick();
      reqBus.req_valid = 1'b0;
      vectors++; if (im_we !== 1'b1 || im_addr !== 8'd1) begin miscompares++; $display("[TB] FAIL jr_write: got we=%0b addr=%0d want we=1 addr=1", im_we, im_addr); end
      vectors++; if (im_wdata !== 32'h03E00008) begin miscompares++; $display("[TB] FAIL jr_wdata: got %h want 03e00008", im_wdata); end
      tick();
      vectors++; if (count !== 9'd2) begin miscompares++; $display("[TB] FAIL jr_count: got %0d want 2", count); end
   endtask

   task automatic test_finish();
      resetDut();
      applyStimulus(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b1);
      tick();
      applyStimulus(5'd1, 5'd4, 5'd5, 5'd6, 5'd9, 26'd0, 1'b0);
      vectors++; if (im_wdata !== 32'h00221820) begin miscompares++; $display("[TB] FAIL fin_add_wdata: got %h want 00221820", im_wdata); end
      tick();
      reqBus.req_valid = 1'b1;
      finish = 1'b1;
      tick();
      reqBus.req_valid = 1'b0;
      vectors++; if (im_we !== 1'b1 || im_addr !== 8'd1) begin miscompares++; $display("[TB] FAIL fin_prio_write: got we=%0b addr=%0d want we=1 addr=1", im_we, im_addr); end
      vectors++; if (im_wdata !== 32'h00853021) begin miscompares++; $display("[TB] FAIL fin_addu_wdata: got %h want 00853021", im_wdata); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL fin_prio_done: got %0b want 0", done); end
      tick();
      vectors++; if (count !== 9'd2 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL fin_idle: got count=%0d done=%0b want count=2 done=0", count, done); end
      tick();
`ifdef ENC_HALT_PAD_EN
      vectors++; if (im_we !== 1'b1 || im_addr !== 8'd2) begin miscompares++; $display("[TB] FAIL halt_write: got we=%0b addr=%0d want we=1 addr=2", im_we, im_addr); end
      vectors++; if (im_wdata !== 32'h08000002) begin miscompares++; $display("[TB] FAIL halt_wdata: got %h want 08000002", im_wdata); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_done_early: got %0b want 0", done); end
      tick();
      vectors++; if (done !== 1'b1 || im_we !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_done: got done=%0b we=%0b want done=1 we=0", done, im_we); end
      vectors++; if (count !== 9'd3) begin miscompares++; $display("[TB] FAIL halt_count: got %0d want 3", count); end
`else
      vectors++; if (done !== 1'b1 || im_we !== 1'b0) begin miscompares++; $display("[TB] FAIL fin_done: got done=%0b we=%0b want done=1 we=0", done, im_we); end
      vectors++; if (count !== 9'd2) begin miscompares++; $display("[TB] FAIL fin_count: got %0d want 2", count); end
`endif
      finish = 1'b0;
      applyStimulus(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b1);
      #1;
      vectors++; if (reqBus.req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL done_ready: got %0b want 0", reqBus.req_ready); end
      tick();
      vectors++; if (im_we !== 1'b0 || done !== 1'b1) begin miscompares++; $display("[TB] FAIL done_hold: got we=%0b done=%0b want we=0 done=1", im_we, done); end
      reqBus.req_valid = 1'b0;
   endtask

   task automatic test_reset_mid_write();
      resetDut();
      applyStimulus(5'd15, 5'd29, 5'd8, 5'd31, 5'd0, 26'h0004, 1'b1);
      tick();
      reqBus.req_valid = 1'b0;
      vectors++; if (im_we !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_we: got %0b want 1", im_we); end
      reset = 1'b1;
      tick();
      vectors++; if (im_we !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_abort_we: got %0b want 0", im_we); end
      vectors++; if (count !== 9'd0 || im_addr !== 8'd0 || im_wdata !== 32'd0) begin miscompares++; $display("[TB] FAIL mid_abort_state: got count=%0d addr=%0d wdata=%h want 0 0 0", count, im_addr, im_wdata); end
      reset = 1'b0;
      tick();
      vectors++; if (reqBus.req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_ready: got %0b want 1", reqBus.req_ready); end
   endtask

   // Run every scenario in order, then report
   initial begin
      reset  = 1'b1;
      finish = 1'b0;
      applyStimulus(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
      test_reset();
      test_encode_full();
      test_illegal_jump();
      test_finish();
      test_reset_mid_write();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
